// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, frame size and default timing.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    WAIT_NEXT,
    HOLD,
    GAP
  } spi_state_e;

  localparam int SPI_BITS       = 8;
  localparam int BIT_W          = $clog2(SPI_BITS);
  localparam int CNT_W          = 8;

  localparam int DEF_CLK_DIV    = 8;
  localparam int DEF_CS_SETUP   = 4;
  localparam int DEF_CS_HOLD    = 4;
  localparam int DEF_CS_GAP     = 4;

  // A phase lasting N cycles is loaded with N-1 and ends on the zero count.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Phase timer: loadable 8-bit down-counter, tick on terminal count while enabled.
// Load takes priority over counting; holds at zero once expired.
module spi_clk_gen
  import spi_pkg::*;
(
  input  logic             system_clk,
  input  logic             system_rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first; done arrives 1+CS_SETUP+16*CLK_DIV cycles after accept.
// start is only taken in IDLE or WAIT_NEXT; anything else is dropped, never queued.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_GAP   = DEF_CS_GAP
) (
  input  logic                system_clk,
  input  logic                system_rst_n,
  input  logic                start,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                keep_cs,
  output logic                busy,
  output logic                done,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                spi_clk,
  output logic                spi_cs,
  output logic                mosi,
  input  logic                miso
);

  if (CLK_DIV < 6 || CLK_DIV > 255 || CS_SETUP < 1 || CS_SETUP > 255 ||
      CS_HOLD < 1 || CS_HOLD > 255 || CS_GAP < 1 || CS_GAP > 255) begin : g_bad_param
    $error("spi_master: timing parameter out of range");
  end

  localparam logic [CNT_W-1:0] DIV_LD   = cnt_load(CLK_DIV);
  localparam logic [CNT_W-1:0] SETUP_LD = cnt_load(CS_SETUP);
  localparam logic [CNT_W-1:0] HOLD_LD  = cnt_load(CS_HOLD);
  localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(CS_GAP);

  spi_state_e            state_q;
  logic [SPI_BITS-2:0]   tx_sh_q;
  logic [SPI_BITS-1:0]   rx_sh_q;
  logic [SPI_BITS-1:0]   rx_data_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sclk_q;
  logic                  cs_q;
  logic                  mosi_q;

  logic                  tick;
  logic                  cnt_ld;
  logic                  cnt_en;
  logic [CNT_W-1:0]      cnt_ld_val;
  logic                  last_bit;

  assign last_bit = (bit_cnt_q == BIT_W'(SPI_BITS - 1));

  // Timer reload mirrors the FSM transitions so each new phase starts full.
  always_comb begin
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld_val = DIV_LD;
    case (state_q)
      IDLE: begin
        cnt_ld     = start;
        cnt_ld_val = SETUP_LD;
      end
      SETUP, LOW: begin
        cnt_en = 1'b1;
        cnt_ld = tick;
      end
      HIGH: begin
        cnt_en = 1'b1;
        cnt_ld = tick;
        if (last_bit && !keep_cs) cnt_ld_val = HOLD_LD;
      end
      WAIT_NEXT: begin
        cnt_ld = !done_q && (start || !keep_cs);
        if (!start) cnt_ld_val = HOLD_LD;
      end
      HOLD: begin
        cnt_en     = 1'b1;
        cnt_ld     = tick;
        cnt_ld_val = GAP_LD;
      end
      GAP: cnt_en = 1'b1;
      default: ;
    endcase
  end

  spi_clk_gen u_clk_gen (
    .system_clk   (system_clk),
    .system_rst_n (system_rst_n),
    .load_i       (cnt_ld),
    .load_val_i   (cnt_ld_val),
    .en_i         (cnt_en),
    .tick_o       (tick)
  );

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q   <= IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SETUP;
            tx_sh_q   <= tx_data[SPI_BITS-2:0];
            mosi_q    <= tx_data[SPI_BITS-1];
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            cs_q      <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) state_q <= LOW;
        end
        LOW: begin
          if (tick) begin
            state_q <= HIGH;
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[SPI_BITS-2:0], miso};
          end
        end
        HIGH: begin
          if (tick) begin
            sclk_q    <= 1'b0;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              mosi_q    <= 1'b0;
              done_q    <= 1'b1;
              rx_data_q <= rx_sh_q;
              state_q   <= keep_cs ? WAIT_NEXT : HOLD;
            end else begin
              mosi_q  <= tx_sh_q[SPI_BITS-2];
              tx_sh_q <= {tx_sh_q[SPI_BITS-3:0], 1'b0};
              state_q <= LOW;
            end
          end
        end
        WAIT_NEXT: begin
          // The done cycle itself is not an opportunity to chain the next byte.
          if (!done_q) begin
            if (start) begin
              tx_sh_q <= tx_data[SPI_BITS-2:0];
              mosi_q  <= tx_data[SPI_BITS-1];
              state_q <= LOW;
            end else if (!keep_cs) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_q    <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign spi_clk = sclk_q;
  assign spi_cs  = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and behavioural mode-0 slave.
module tb_spi_master;

  logic       system_clk = 1'b0;
  logic       system_rst_n;
  logic       start, keep_cs, busy, done, spi_clk, spi_cs, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       start2, keep2, busy2, done2, sclk2, cs2, mosi2, miso2;
  logic [7:0] tx2, rx2;
  logic       use_slave, sel2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] slv_send = 8'h00;
  logic [7:0] slv_tx_sh = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic [7:0] slv_received = 8'h00;
  logic       slv_ready = 1'b0;
  logic       slv_prev = 1'b0;
  int         slv_cnt = 0;
  logic       s_cs, s_clk, s_mosi;

  spi_master dut (
    .system_clk(system_clk), .system_rst_n(system_rst_n), .start(start), .tx_data(tx_data),
    .keep_cs(keep_cs), .busy(busy), .done(done), .rx_data(rx_data), .spi_clk(spi_clk),
    .spi_cs(spi_cs), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(6), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut2 (
    .system_clk(system_clk), .system_rst_n(system_rst_n), .start(start2), .tx_data(tx2),
    .keep_cs(keep2), .busy(busy2), .done(done2), .rx_data(rx2), .spi_clk(sclk2),
    .spi_cs(cs2), .mosi(mosi2), .miso(miso2)
  );

  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) cyc <= cyc + 1;

  assign s_cs   = sel2 ? cs2   : spi_cs;
  assign s_clk  = sel2 ? sclk2 : spi_clk;
  assign s_mosi = sel2 ? mosi2 : mosi;
  assign miso   = use_slave ? slv_tx_sh[7] : mosi;
  assign miso2  = slv_tx_sh[7];

  // Mode-0 slave: load on CS fall, sample on SCLK rise, shift out on SCLK fall.
  always @(negedge s_cs or posedge s_clk or negedge s_clk) begin
    if (s_cs === 1'b0) begin
      if (s_clk && !slv_prev) begin
        slv_rx = {slv_rx[6:0], s_mosi};
        slv_cnt++;
        if (slv_cnt == 8) begin
          slv_received = slv_rx;
          slv_ready    = 1'b1;
          slv_cnt      = 0;
        end
      end else if (!s_clk && slv_prev) begin
        slv_tx_sh = {slv_tx_sh[6:0], 1'b0};
      end else begin
        slv_tx_sh = slv_send;
        slv_cnt   = 0;
        slv_ready = 1'b0;
      end
    end
    slv_prev = s_clk;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  task automatic test_reset;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b want 0", spi_clk); end
    vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b want 1", spi_cs); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b want 0", mosi); end
  endtask

  task automatic test_single;
    int t0, nr, nf, ndone, dcyc, csr, bad;
    int rise[16];
    int fall[16];
    logic prev;
    logic [7:0] r;
    use_slave = 1'b0;
    tx_data = 8'hA5; keep_cs = 1'b0; start = 1'b1; t0 = cyc;
    cyc_wait(1); start = 1'b0;
    vectors++; if (spi_cs !== 1'b0) begin miscompares++; $display("FAIL single_cs_fall: got %b want 0 at T+1", spi_cs); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
    nr = 0; nf = 0; ndone = 0; dcyc = -1; csr = -1; r = 8'h00; prev = spi_clk;
    for (int i = 0; i < 300 && busy; i++) begin
      @(negedge system_clk);
      if (spi_clk && !prev && nr < 16) begin rise[nr] = cyc; nr++; end
      if (!spi_clk && prev && nf < 16) begin fall[nf] = cyc; nf++; end
      if (done) begin ndone++; dcyc = cyc; r = rx_data; end
      if (spi_cs && csr < 0) csr = cyc;
      prev = spi_clk;
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_timeout: busy %b want 0", busy); end
    vectors++; if (cyc !== t0 + 141) begin miscompares++; $display("FAIL single_idle_cycle: got T+%0d want T+141", cyc - t0); end
    vectors++; if (nr !== 8) begin miscompares++; $display("FAIL single_rises: got %0d want 8", nr); end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d want 1", ndone); end
    vectors++; if (dcyc !== t0 + 133) begin miscompares++; $display("FAIL single_done_cycle: got T+%0d want T+133", dcyc - t0); end
    vectors++; if (r !== 8'hA5) begin miscompares++; $display("FAIL single_rx: got %h want a5", r); end
    vectors++; if (csr !== t0 + 137) begin miscompares++; $display("FAIL single_cs_rise: got T+%0d want T+137", csr - t0); end
    if (nr == 8 && nf == 8) begin
      vectors++; if (rise[0] !== t0 + 13) begin miscompares++; $display("FAIL single_first_rise: got T+%0d want T+13", rise[0] - t0); end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        if (fall[k] - rise[k] != 8) bad++;
        if (k > 0 && rise[k] - fall[k-1] != 8) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL single_phase_len: %0d phases not 8 cycles, want 0", bad); end
    end
    cyc_wait(3);
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL single_rx_hold: got %h want a5", rx_data); end
  endtask

  task automatic test_slave;
    int got;
    use_slave = 1'b1; slv_send = 8'hC3;
    tx_data = 8'h3C; keep_cs = 1'b0; start = 1'b1;
    cyc_wait(1); start = 1'b0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done) got = 1; else @(negedge system_clk);
    end
    vectors++; if (got !== 1) begin miscompares++; $display("FAIL slave_timeout: done seen %0d want 1", got); end
    vectors++; if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL slave_master_rx: got %h want c3", rx_data); end
    vectors++; if (slv_received !== 8'h3C) begin miscompares++; $display("FAIL slave_rx: got %h want 3c", slv_received); end
    vectors++; if (slv_ready !== 1'b1) begin miscompares++; $display("FAIL slave_ready: got %b want 1", slv_ready); end
    for (int i = 0; i < 20 && busy; i++) @(negedge system_clk);
    use_slave = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[3];
    logic [7:0] rxs[3];
    int got, cs_hi, busy_lo;
    bytes = '{8'h01, 8'h80, 8'hFF};
    cs_hi = 0; busy_lo = 0;
    for (int b = 0; b < 3; b++) begin
      tx_data = bytes[b]; keep_cs = (b < 2); start = 1'b1;
      cyc_wait(1); start = 1'b0;
      got = 0; rxs[b] = 8'hxx;
      for (int i = 0; i < 200 && !got; i++) begin
        if (spi_cs) cs_hi++;
        if (!busy) busy_lo++;
        if (done) begin got = 1; rxs[b] = rx_data; end
        else @(negedge system_clk);
      end
      vectors++; if (got !== 1) begin miscompares++; $display("FAIL burst_done%0d: seen %0d want 1", b, got); end
      if (b < 2) cyc_wait(1);
    end
    keep_cs = 1'b0;
    vectors++; if (rxs[0] !== 8'h01) begin miscompares++; $display("FAIL burst_rx0: got %h want 01", rxs[0]); end
    vectors++; if (rxs[1] !== 8'h80) begin miscompares++; $display("FAIL burst_rx1: got %h want 80", rxs[1]); end
    vectors++; if (rxs[2] !== 8'hFF) begin miscompares++; $display("FAIL burst_rx2: got %h want ff", rxs[2]); end
    vectors++; if (cs_hi !== 0) begin miscompares++; $display("FAIL burst_cs_low: cs high %0d cycles want 0", cs_hi); end
    vectors++; if (busy_lo !== 0) begin miscompares++; $display("FAIL burst_busy: busy low %0d cycles want 0", busy_lo); end
    cyc_wait(3);
    vectors++; if (spi_cs !== 1'b0) begin miscompares++; $display("FAIL burst_hold: cs %b want 0 at D+3", spi_cs); end
    cyc_wait(1);
    vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL burst_cs_release: cs %b want 1 at D+4", spi_cs); end
    cyc_wait(3);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL burst_gap_busy: busy %b want 1 at D+7", busy); end
    cyc_wait(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL burst_idle: busy %b want 0 at D+8", busy); end
  endtask

  task automatic test_start_ignored;
    int t0, nd, nfall, lows, d1, d2, cr, cf;
    logic prev;
    logic [7:0] r;
    tx_data = 8'h96; keep_cs = 1'b0; start = 1'b1;
    cyc_wait(1); start = 1'b0;
    cyc_wait(40); tx_data = 8'h0F; start = 1'b1;
    cyc_wait(1); start = 1'b0;
    nd = 0; nfall = 0; r = 8'h00; prev = spi_cs;
    for (int i = 0; i < 200 && busy; i++) begin
      @(negedge system_clk);
      if (done) begin nd++; r = rx_data; end
      if (prev && !spi_cs) nfall++;
      prev = spi_cs;
    end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    vectors++; if (r !== 8'h96) begin miscompares++; $display("FAIL ignore_rx: got %h want 96", r); end
    vectors++; if (nfall !== 0) begin miscompares++; $display("FAIL ignore_extra_cs: got %0d falls want 0", nfall); end
    lows = 0;
    for (int i = 0; i < 20; i++) begin @(negedge system_clk); if (!spi_cs || busy) lows++; end
    vectors++; if (lows !== 0) begin miscompares++; $display("FAIL ignore_no_queue: %0d active cycles want 0", lows); end

    tx_data = 8'h3A; start = 1'b1; t0 = cyc;
    nd = 0; d1 = -1; d2 = -1; cr = -1; cf = -1; prev = spi_cs; r = 8'h00;
    for (int i = 0; i < 400 && nd < 2; i++) begin
      @(negedge system_clk);
      if (done) begin nd++; if (nd == 1) d1 = cyc; else d2 = cyc; r = rx_data; end
      if (!prev && spi_cs && cr < 0) cr = cyc;
      if (prev && !spi_cs && cyc > t0 + 1 && cf < 0) cf = cyc;
      prev = spi_cs;
    end
    start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge system_clk);
    vectors++; if (d1 !== t0 + 133) begin miscompares++; $display("FAIL held_done1: got T+%0d want T+133", d1 - t0); end
    vectors++; if (cr !== t0 + 137) begin miscompares++; $display("FAIL held_cs_rise: got T+%0d want T+137", cr - t0); end
    vectors++; if (cf !== t0 + 142) begin miscompares++; $display("FAIL held_cs_refall: got T+%0d want T+142", cf - t0); end
    vectors++; if (d2 !== t0 + 274) begin miscompares++; $display("FAIL held_done2: got T+%0d want T+274", d2 - t0); end
    vectors++; if (r !== 8'h3A) begin miscompares++; $display("FAIL held_rx: got %h want 3a", r); end
  endtask

  task automatic test_reset_mid;
    int t0, nd, lows, got, dcyc;
    tx_data = 8'hC6; keep_cs = 1'b0; start = 1'b1;
    cyc_wait(1); start = 1'b0;
    cyc_wait(62);
    vectors++; if (spi_clk !== 1'b1) begin miscompares++; $display("FAIL mid_in_high: sclk %b want 1", spi_clk); end
    #1 system_rst_n = 1'b0;
    #1;
    vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL mid_cs: got %b want 1", spi_cs); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL mid_sclk: got %b want 0", spi_clk); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL mid_mosi: got %b want 0", mosi); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL mid_rx: got %h want 00", rx_data); end
    nd = 0; lows = 0;
    for (int i = 0; i < 5; i++) begin @(negedge system_clk); if (done) nd++; end
    system_rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin @(negedge system_clk); if (done) nd++; if (!spi_cs) lows++; end
    vectors++; if (nd !== 0) begin miscompares++; $display("FAIL mid_no_done: got %0d pulses want 0", nd); end
    vectors++; if (lows !== 0) begin miscompares++; $display("FAIL mid_cs_idle: %0d low cycles want 0", lows); end
    tx_data = 8'h5A; start = 1'b1; t0 = cyc;
    cyc_wait(1); start = 1'b0;
    got = 0; dcyc = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done) begin got = 1; dcyc = cyc; end else @(negedge system_clk);
    end
    vectors++; if (dcyc !== t0 + 133) begin miscompares++; $display("FAIL mid_recover_done: got T+%0d want T+133", dcyc - t0); end
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL mid_recover_rx: got %h want 5a", rx_data); end
    for (int i = 0; i < 20 && busy; i++) @(negedge system_clk);
  endtask

  task automatic test_fast;
    int t0, got, dcyc;
    sel2 = 1'b1; slv_send = 8'hE7;
    cyc_wait(1);
    tx2 = 8'hE7; start2 = 1'b1; t0 = cyc;
    cyc_wait(1); start2 = 1'b0;
    vectors++; if (cs2 !== 1'b0) begin miscompares++; $display("FAIL fast_cs_fall: got %b want 0 at T+1", cs2); end
    got = 0; dcyc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done2) begin got = 1; dcyc = cyc; end else @(negedge system_clk);
    end
    vectors++; if (dcyc !== t0 + 98) begin miscompares++; $display("FAIL fast_done_cycle: got T+%0d want T+98", dcyc - t0); end
    vectors++; if (rx2 !== 8'hE7) begin miscompares++; $display("FAIL fast_master_rx: got %h want e7", rx2); end
    vectors++; if (slv_received !== 8'hE7) begin miscompares++; $display("FAIL fast_slave_rx: got %h want e7", slv_received); end
    vectors++; if (slv_ready !== 1'b1) begin miscompares++; $display("FAIL fast_slave_ready: got %b want 1", slv_ready); end
    for (int i = 0; i < 10 && busy2; i++) @(negedge system_clk);
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL fast_idle: busy %b want 0", busy2); end
  endtask

  initial begin
    start = 1'b0; tx_data = 8'h00; keep_cs = 1'b0;
    start2 = 1'b0; tx2 = 8'h00; keep2 = 1'b0;
    use_slave = 1'b0; sel2 = 1'b0;
    system_rst_n = 1'b1;
    #2 system_rst_n = 1'b0;
    cyc_wait(3);
    system_rst_n = 1'b1;
    cyc_wait(1);
    test_reset;
    test_single;
    test_slave;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid;
    test_fast;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 SPI master: drives spi_clk, spi_cs and mosi; samples miso. Counterpart of the on-chip SPI slave.
- Used by the board test harness and the loopback bench to exercise the slave.
- Full-duplex byte transfers, MSB first, with optional back-to-back bytes under one chip-select.
- Timing is sized for a slave that synchronises spi_clk through a 3-flop chain, so every SCLK phase is at least CLK_DIV system clocks.

Parameters:
- CLK_DIV, 8: system_clk cycles per SCLK half-period; legal range 6..255 (elaboration error otherwise).
- CS_SETUP, 4: cycles spi_cs is low before the first SCLK low phase begins; legal 1..255.
- CS_HOLD, 4: cycles spi_cs stays low after the last SCLK falling edge; legal 1..255.
- CS_GAP, 4: minimum cycles spi_cs is high before busy drops; legal 1..255.

Ports:
- system_clk input 1 System clock; all logic on the rising edge.
- system_rst_n input 1 Reset: asynchronous assert, active-low.
- start input 1 Transfer request; accepted when busy=0, or when in WAIT_NEXT.
- tx_data input 8 Byte to send; captured on the accept cycle.
- keep_cs input 1 Sampled on the done cycle: 1 keeps spi_cs low and enters WAIT_NEXT.
- busy output 1 High from the accept cycle until the end of the GAP phase (WAIT_NEXT counts as busy).
- done output 1 One-cycle pulse when a byte completes.
- rx_data output 8 Received byte; updated on the done cycle, then held.
- spi_clk output 1 SCLK, idle low (CPOL=0).
- spi_cs output 1 Chip select, active low.
- mosi output 1 Master data out.
- miso input 1 Slave data in.

Behaviour:
- Reset values: busy=0, done=0, rx_data=0, spi_clk=0, spi_cs=1, mosi=0. All internal counters and shift registers are cleared.
- Reset asserted mid-transfer aborts immediately: spi_cs=1, spi_clk=0, and no done pulse is issued.
- All SPI outputs are registered; there is no combinational path from the inputs to the pins.
- States and transitions:
  - IDLE: start=1 -> SETUP. tx_data is latched into tx_sh, busy=1, spi_cs=0 next cycle, mosi=tx_data[7] next cycle.
  - SETUP: CS_SETUP cycles -> LOW.
  - LOW: spi_clk=0 for CLK_DIV cycles. Then spi_clk goes to 1 and miso is shifted into rx_sh on that same system_clk edge -> HIGH.
  - HIGH: spi_clk=1 for CLK_DIV cycles, then spi_clk goes to 0.
    - Bits 0..6: mosi advances to the next lower bit on that same edge -> LOW.
    - 8th bit: mosi=0, done=1, rx_data={rx_sh[6:0],miso-sampled} -> keep_cs ? WAIT_NEXT : HOLD.
  - WAIT_NEXT: spi_cs=0, spi_clk=0, busy=1. start=1 latches tx_data -> LOW directly (no SETUP), mosi=tx_data[7] next cycle. keep_cs=0 with start=0 -> HOLD.
  - HOLD: CS_HOLD cycles -> spi_cs=1 -> GAP.
  - GAP: CS_GAP cycles -> IDLE, busy=0. The first cycle with busy=0 is the cycle the state is IDLE.
- Latency: start accepted at cycle T -> spi_cs low at T+1 -> first SCLK rise at T+1+CS_SETUP+CLK_DIV -> done at T+1+CS_SETUP+16*CLK_DIV.
- start while busy=1, outside WAIT_NEXT, is ignored; no queuing.
- start and keep_cs in the same cycle as done have no start effect. The start must arrive in WAIT_NEXT.
- Bit counter is 3 bits. It wraps 7->0 on the 8th falling edge, which is the done condition.
- Half-period counter width is 8 bits and counts CLK_DIV-1 down to 0.
- miso is used raw; the master owns SCLK, so no synchroniser is needed.

Decomposition:
- Package spi_pkg: state encoding constants (IDLE, SETUP, LOW, HIGH, WAIT_NEXT, HOLD, GAP), SPI_BITS=8, and the default timing constants, shared with the slave bench.
- One natural sub-module: spi_clk_gen. It is the half-period down-counter, taking a load/enable and producing a tick on the terminal count. The FSM and shift registers stay in spi_master.

Test Plan:
- Single byte, loopback miso=mosi, tx_data=8'hA5, defaults:
  - spi_cs falls at T+1, done at T+133, rx_data=8'hA5.
  - Exactly 8 rising edges, each with high phase=8 and low phase=8 cycles.
- Against the slave model, tx_data=8'h3C, slave data_to_send=8'hC3:
  - master rx_data=8'hC3, slave received_data=8'h3C, slave data_ready=1.
- Burst 8'h01, 8'h80, 8'hFF with keep_cs=1 on the first two done cycles:
  - spi_cs stays low across all three bytes, three done pulses, rx_data in order.
  - busy stays 1 until the GAP phase ends.
- start pulsed during a byte, and start held high continuously:
  - the extra start is ignored, only one transfer occurs.
  - the next transfer begins only after GAP, re-running SETUP.
- system_rst_n low during the 4th HIGH phase:
  - outputs show reset values asynchronously, no done pulse.
  - after release, a new start with 8'h5A completes normally.
- CLK_DIV=6, CS_SETUP=1, CS_HOLD=1, CS_GAP=1 against the slave with 8'hE7 both ways:
  - both sides receive 8'hE7, done at T+98.
